qresult_stage: RTL and testbench
================================

Name: qresult_stage

Overview:
- Final stage of the lookup pipeline. Sits directly downstream of the last search-tree stage.
- Consumes the leaf address, key and enable produced by the tree stages, reads a leaf-result RAM, and buffers results in a show-ahead FIFO with valid/ready output.
- The tree pipeline cannot stall, so the block exports almost_full_o to the request ingress for early throttling.
- An overflow is detected and made sticky.

Parameters:
- A_WIDTH, 4: width of leaf address from last tree stage; leaf RAM depth is 2**A_WIDTH.
- D_WIDTH, 16: lookup key width.
- R_WIDTH, 8: result word width.
- FIFO_DEPTH, 8: result FIFO entries; power of 2, >= 2.
- SLACK, 6: lookups that may still arrive after almost_full_o asserts; 1 <= SLACK < FIFO_DEPTH.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- res_wr_en_i  in  1  leaf RAM write enable (control plane)
- res_wr_addr_i  in  A_WIDTH  leaf RAM write address
- res_wr_data_i  in  R_WIDTH  leaf RAM write data
- lookup_en_i  in  1  lookup valid from last tree stage
- lookup_addr_i  in  A_WIDTH  leaf address
- lookup_data_i  in  D_WIDTH  lookup key
- res_valid_o  out  1  FIFO head valid
- res_ready_i  in  1  consumer ready
- res_data_o  out  R_WIDTH  leaf result at head
- res_key_o  out  D_WIDTH  key at head
- res_addr_o  out  A_WIDTH  leaf address at head
- used_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- almost_full_o  out  1  throttle to ingress
- overflow_o  out  1  sticky drop flag

Behaviour:
- Reset: one clock, clk_i; reset rst_n_i is asynchronous and active-low.
  - Asserting rst_n_i empties the FIFO and clears all pipeline valids, overflow_o and counters, at any time, including mid-burst.
  - Reset values: res_valid_o=0, used_o=0, almost_full_o=0, overflow_o=0, res_data_o/res_key_o/res_addr_o=0.
  - Leaf RAM contents are not reset.
- Leaf RAM: 2**A_WIDTH x R_WIDTH, synchronous write, registered read at lookup_addr_i every cycle.
  - Read and write to the same address in the same cycle returns the old data (read-first).
- Pipeline:
  - Cycle t: lookup_en_i/addr/key sampled; RAM read issued.
  - Cycle t+1: RAM q and the delayed en/addr/key form the push word.
  - Push at the end of t+1.
  - res_valid_o rises in cycle t+2 when the FIFO was empty; min latency 2 clocks.
  - One lookup per cycle sustained; no bubbles inserted.
- FIFO: show-ahead; head outputs are valid whenever res_valid_o=1.
  - Pop occurs when res_valid_o && res_ready_i.
  - res_ready_i with an empty FIFO has no effect.
  - While res_valid_o && !res_ready_i, the head outputs are held stable.
  - Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; used_o is a separate counter.
  - Push and pop in the same cycle: used_o unchanged, ordering preserved. This includes the full case: a push is accepted when full if a pop happens in the same cycle.
  - Push when full without pop: entry dropped, used_o stays FIFO_DEPTH, overflow_o set to 1 and held until reset.
- almost_full_o = (used_o >= FIFO_DEPTH - SLACK), decoded from the registered used_o; no added latency.
- lookup_en_i=0 cycles: no push; addr/key inputs are ignored for state.

Optional Feature:
- QRESULT_STATS_EN defined: adds outputs lookup_cnt_o [31:0] and drop_cnt_o [31:0].
  - lookup_cnt_o counts accepted pushes.
  - drop_cnt_o counts dropped pushes.
  - Both saturate at 32'hFFFFFFFF and are reset to 0 by rst_n_i.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then single lookup: write RAM[5]=8'hA5; lookup_en_i=1, addr=5, key=16'h1234 at cycle t, res_ready_i=1 -> res_valid_o=1 at t+2 with data=A5, key=1234, addr=5 for one cycle; used_o returns to 0.
- Back-pressure fill: res_ready_i=0, 8 consecutive lookups to addr 0..7 (DEPTH=8, SLACK=6) -> almost_full_o rises the cycle used_o reaches 2; used_o=8; overflow_o=0. Then res_ready_i=1 drains results in order 0..7 at one per cycle.
- Overflow: full FIFO, res_ready_i=0, 9th lookup -> used_o stays 8, overflow_o=1 sticky; head unchanged; with QRESULT_STATS_EN, drop_cnt_o=1 and lookup_cnt_o=8.
- Full with simultaneous push/pop: used_o=8, res_ready_i=1, lookup_en_i=1 -> no drop, used_o=8, new entry appears last in drain order.
- Read-during-write: RAM[3]=11; same cycle res_wr_en_i (addr 3, data 22) and lookup addr 3 -> result 11; next lookup to 3 -> 22.
- Mid-operation reset: FIFO holding 5 entries, overflow_o=1; pulse rst_n_i low asynchronously -> res_valid_o, used_o, almost_full_o and overflow_o are 0 immediately; lookups in flight are discarded.

Source files
------------

// File: rtl/qresult_stage.sv
// Final lookup stage: leaf-result RAM read, then a show-ahead result FIFO with valid/ready output.
// Define QRESULT_STATS_EN to add saturating lookup_cnt_o / drop_cnt_o counters.
module qresult_stage #(
  parameter int A_WIDTH    = 4,
  parameter int D_WIDTH    = 16,
  parameter int R_WIDTH    = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int SLACK      = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          res_wr_en_i,
  input  logic [A_WIDTH-1:0]            res_wr_addr_i,
  input  logic [R_WIDTH-1:0]            res_wr_data_i,
  input  logic                          lookup_en_i,
  input  logic [A_WIDTH-1:0]            lookup_addr_i,
  input  logic [D_WIDTH-1:0]            lookup_data_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [R_WIDTH-1:0]            res_data_o,
  output logic [D_WIDTH-1:0]            res_key_o,
  output logic [A_WIDTH-1:0]            res_addr_o,
  output logic [$clog2(FIFO_DEPTH):0]   used_o,
`ifdef QRESULT_STATS_EN
  output logic [31:0]                   lookup_cnt_o,
  output logic [31:0]                   drop_cnt_o,
`endif
  output logic                          almost_full_o,
  output logic                          overflow_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int UW = PW + 1;
  localparam int WW = R_WIDTH + D_WIDTH + A_WIDTH;
  localparam logic [UW-1:0] DEPTH_U = UW'(FIFO_DEPTH);
  localparam logic [UW-1:0] AF_LVL  = UW'(FIFO_DEPTH - SLACK);

  logic [R_WIDTH-1:0] leaf_mem [2**A_WIDTH];
  logic [WW-1:0]      fifo_mem [FIFO_DEPTH];

  logic [R_WIDTH-1:0] rd_data_q;
  logic               s1_valid_q, s1_valid_d;
  logic [A_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [D_WIDTH-1:0] s1_key_q, s1_key_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]      used_q, used_d;
  logic               overflow_q, overflow_d;

  logic               full, pop, push_ok, drop;
  logic [WW-1:0]      push_word, head_word;

  // Leaf RAM and FIFO storage are not reset; nonblocking read gives read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (res_wr_en_i) leaf_mem[res_wr_addr_i] <= res_wr_data_i;
    rd_data_q <= leaf_mem[lookup_addr_i];
    if (push_ok) fifo_mem[wr_ptr_q] <= push_word;
  end

  always_comb begin
    full      = (used_q == DEPTH_U);
    pop       = res_valid_o && res_ready_i;
    push_ok   = s1_valid_q && (!full || pop);
    drop      = s1_valid_q && full && !pop;
    push_word = {rd_data_q, s1_key_q, s1_addr_q};

    s1_valid_d = lookup_en_i;
    s1_addr_d  = s1_addr_q;
    s1_key_d   = s1_key_q;
    if (lookup_en_i) begin
      s1_addr_d = lookup_addr_i;
      s1_key_d  = lookup_data_i;
    end

    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    used_d     = used_q;
    case ({push_ok, pop})
      2'b10:   used_d = used_q + UW'(1);
      2'b01:   used_d = used_q - UW'(1);
      default: used_d = used_q;
    endcase
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_key_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_key_q   <= s1_key_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      used_q     <= used_d;
      overflow_q <= overflow_d;
    end
  end

  // Head fields are forced to zero while empty so stale storage never leaks out.
  always_comb begin
    head_word     = fifo_mem[rd_ptr_q];
    res_valid_o   = (used_q != '0);
    res_data_o    = res_valid_o ? head_word[WW-1 -: R_WIDTH] : '0;
    res_key_o     = res_valid_o ? head_word[A_WIDTH +: D_WIDTH] : '0;
    res_addr_o    = res_valid_o ? head_word[A_WIDTH-1:0] : '0;
    used_o        = used_q;
    almost_full_o = (used_q >= AF_LVL);
    overflow_o    = overflow_q;
  end

`ifdef QRESULT_STATS_EN
  logic [31:0] lookup_cnt_q, lookup_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    lookup_cnt_d = lookup_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (push_ok && lookup_cnt_q != 32'hFFFF_FFFF) lookup_cnt_d = lookup_cnt_q + 32'd1;
    if (drop && drop_cnt_q != 32'hFFFF_FFFF)      drop_cnt_d   = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lookup_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      lookup_cnt_q <= lookup_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign lookup_cnt_o = lookup_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_qresult_stage.sv
// Directed bench for qresult_stage: vector table for fill/overflow/drain plus hand sequences.
module tb_qresult_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        en = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] key = '0;
  logic        rdy = 1'b0;
  logic        valid;
  logic [7:0]  data_o;
  logic [15:0] key_o;
  logic [3:0]  addr_o;
  logic [3:0]  used;
  logic        af, ovf;
`ifdef QRESULT_STATS_EN
  logic [31:0] lookup_cnt, drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  qresult_stage dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .res_wr_en_i(wr_en), .res_wr_addr_i(wr_addr), .res_wr_data_i(wr_data),
    .lookup_en_i(en), .lookup_addr_i(addr), .lookup_data_i(key),
    .res_valid_o(valid), .res_ready_i(rdy),
    .res_data_o(data_o), .res_key_o(key_o), .res_addr_o(addr_o),
    .used_o(used),
`ifdef QRESULT_STATS_EN
    .lookup_cnt_o(lookup_cnt), .drop_cnt_o(drop_cnt),
`endif
    .almost_full_o(af), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM is preloaded with data = 0x30 + address; keys used are 0x1000 + address.
  task automatic chk_head(input string tag, input logic [3:0] a);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_addr"}, 32'(addr_o), 32'(a));
    chk({tag, "_data"}, 32'(data_o), 32'h30 + 32'(a));
    chk({tag, "_key"}, 32'(key_o), 32'h1000 + 32'(a));
  endtask

  typedef struct {
    logic       en;
    logic [3:0] addr;
    logic       rdy;
    logic       v;
    logic [3:0] hd;
    logic [3:0] used;
    logic       af;
    logic       ovf;
  } vec_t;

  vec_t vt[22];

  function automatic vec_t mk(input logic e, input logic [3:0] a, input logic r,
                              input logic v, input logic [3:0] h, input logic [3:0] u,
                              input logic f, input logic o);
    vec_t x;
    x.en = e; x.addr = a; x.rdy = r; x.v = v; x.hd = h; x.used = u; x.af = f; x.ovf = o;
    return x;
  endfunction

  logic [3:0] order[8];

  initial begin
    vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(1, 2, 0, 1, 0, 1, 0, 0);
    vt[3]  = mk(1, 3, 0, 1, 0, 2, 1, 0);
    vt[4]  = mk(1, 4, 0, 1, 0, 3, 1, 0);
    vt[5]  = mk(1, 5, 0, 1, 0, 4, 1, 0);
    vt[6]  = mk(1, 6, 0, 1, 0, 5, 1, 0);
    vt[7]  = mk(1, 7, 0, 1, 0, 6, 1, 0);
    vt[8]  = mk(0, 0, 0, 1, 0, 7, 1, 0);
    vt[9]  = mk(0, 0, 0, 1, 0, 8, 1, 0);
    vt[10] = mk(1, 9, 0, 1, 0, 8, 1, 0);
    vt[11] = mk(0, 0, 0, 1, 0, 8, 1, 0);
    vt[12] = mk(0, 0, 0, 1, 0, 8, 1, 1);
    vt[13] = mk(0, 0, 1, 1, 0, 8, 1, 1);
    vt[14] = mk(0, 0, 1, 1, 1, 7, 1, 1);
    vt[15] = mk(0, 0, 1, 1, 2, 6, 1, 1);
    vt[16] = mk(0, 0, 1, 1, 3, 5, 1, 1);
    vt[17] = mk(0, 0, 1, 1, 4, 4, 1, 1);
    vt[18] = mk(0, 0, 1, 1, 5, 3, 1, 1);
    vt[19] = mk(0, 0, 1, 1, 6, 2, 1, 1);
    vt[20] = mk(0, 0, 1, 1, 7, 1, 0, 1);
    vt[21] = mk(0, 0, 1, 0, 0, 0, 0, 1);

    // Reset state
    #12;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_used", 32'(used), 0);
    chk("rst_af", 32'(af), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_key", 32'(key_o), 0);
    chk("rst_addr", 32'(addr_o), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'h30 + 8'(i);
      tick();
    end
    wr_en = 1'b0;

    // Fill, overflow, in-order drain
    for (int i = 0; i < 22; i++) begin
      en = vt[i].en; addr = vt[i].addr; key = 16'h1000 + 16'(vt[i].addr); rdy = vt[i].rdy;
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vt[i].v));
      chk($sformatf("vec%0d_used", i), 32'(used), 32'(vt[i].used));
      chk($sformatf("vec%0d_af", i), 32'(af), 32'(vt[i].af));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].ovf));
      chk($sformatf("vec%0d_addr", i), 32'(addr_o), vt[i].v ? 32'(vt[i].hd) : 32'd0);
      chk($sformatf("vec%0d_data", i), 32'(data_o), vt[i].v ? 32'h30 + 32'(vt[i].hd) : 32'd0);
      chk($sformatf("vec%0d_key", i), 32'(key_o), vt[i].v ? 32'h1000 + 32'(vt[i].hd) : 32'd0);
      tick();
    end
`ifdef QRESULT_STATS_EN
    chk("stats_lookup", lookup_cnt, 32'd8);
    chk("stats_drop", drop_cnt, 32'd1);
`endif

    // Mid-operation reset: 5 queued, one in flight, overflow still set
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = 1'b1; addr = 4'(i); key = 16'h1000 + 16'(i);
      tick();
    end
    en = 1'b0;
    chk("mr_pre_used", 32'(used), 5);
    chk("mr_pre_ovf", 32'(ovf), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(valid), 0);
    chk("mr_used", 32'(used), 0);
    chk("mr_af", 32'(af), 0);
    chk("mr_ovf", 32'(ovf), 0);
    tick();
    #2 rst_n = 1'b1;
    tick(); tick();
    chk("mr_post_used", 32'(used), 0);
    chk("mr_post_valid", 32'(valid), 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 9; i++) begin
      en = 1'b1; addr = (i == 8) ? 4'd9 : 4'(i); key = 16'h1000 + 16'(addr);
      tick();
    end
    en = 1'b0;
    chk("pp_used_full", 32'(used), 8);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("pp_used_after", 32'(used), 8);
    chk("pp_ovf", 32'(ovf), 0);
    chk_head("pp_head", 4'd1);
    order = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("pp_drain%0d", i), order[i]);
      tick();
    end
    chk("pp_empty", 32'(used), 0);

    // Single lookup latency
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    en = 1'b1; addr = 4'd5; key = 16'h1234;
    tick();
    en = 1'b0; addr = 4'd0; key = 16'h0;
    chk("sl_t1_valid", 32'(valid), 0);
    tick();
    chk("sl_valid", 32'(valid), 1);
    chk("sl_data", 32'(data_o), 32'hA5);
    chk("sl_key", 32'(key_o), 32'h1234);
    chk("sl_addr", 32'(addr_o), 5);
    tick();
    chk("sl_t3_valid", 32'(valid), 0);
    chk("sl_t3_used", 32'(used), 0);

    // Read-during-write returns old data
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h11;
    tick();
    wr_data = 8'h22; en = 1'b1; addr = 4'd3; key = 16'h0003;
    tick();
    wr_en = 1'b0; key = 16'h0004;
    tick();
    en = 1'b0;
    chk("rdw_old_data", 32'(data_o), 32'h11);
    chk("rdw_old_key", 32'(key_o), 32'h0003);
    tick();
    chk("rdw_new_data", 32'(data_o), 32'h22);
    chk("rdw_new_key", 32'(key_o), 32'h0004);
    tick();
    chk("rdw_empty", 32'(valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
